// File: rtl/mic1_datapath_register_if.sv
// Port bundle for a MIC-1 datapath register: C-bus capture side plus the always-on local copy.
// The tri-state B-bus output stays a plain net so that several registers can share one bus.
interface mic1_datapath_register_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] dataIn;
    logic             inEnable;
    logic             outEnable;
    logic [WIDTH-1:0] alwaysOnDataOut;

    modport master (
        output dataIn,
        output inEnable,
        output outEnable,
        input  alwaysOnDataOut
    );

    modport slave (
        input  dataIn,
        input  inEnable,
        input  outEnable,
        output alwaysOnDataOut
    );
endinterface

// File: rtl/mic1_datapath_register.sv
// MIC-1 general-purpose datapath register: captures the C-bus when write-enabled and
// drives the shared B-bus through a tri-state output gated by outEnable.
module mic1_datapath_register #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset,
    mic1_datapath_register_if.slave regBus,
    output wire [WIDTH-1:0]     dataOut
);
    logic [WIDTH-1:0] storageQ;

    // An X/Z write enable falls through to the hold branch, so it never loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            storageQ <= RESET_VALUE;
        end else if (regBus.inEnable) begin
            storageQ <= regBus.dataIn;
        end
    end

    assign regBus.alwaysOnDataOut = storageQ;

    // Combinational bus drive; no write-through, so the old word shows until the edge.
    assign dataOut = regBus.outEnable ? storageQ : {WIDTH{1'bz}};
endmodule

// File: tb/tb_mic1_datapath_register.sv
// Self-checking bench for mic1_datapath_register: directed test-plan steps followed by
// randomized traffic checked against a simple "current stored word" model.
module tb_mic1_datapath_register;
    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] RESET_VALUE = '0;

    logic             clock;
    logic             reset;
    wire  [WIDTH-1:0] dataOut;

    mic1_datapath_register_if #(.WIDTH(WIDTH)) regBus ();

    mic1_datapath_register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .regBus (regBus.slave),
        .dataOut(dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [WIDTH-1:0] model;
    int unsigned      passCount;
    int unsigned      totalCount;

    // Compare both outputs against the model; bus expectation derives from the enable.
    task automatic check(input string tag);
        logic [WIDTH-1:0] expOut;
        expOut = (regBus.outEnable === 1'b1) ? model : {WIDTH{1'bz}};
        totalCount++;
        assert (regBus.alwaysOnDataOut === model) passCount++;
        else $error("FAIL %s alwaysOnDataOut got %h expected %h", tag,
                    regBus.alwaysOnDataOut, model);
        totalCount++;
        assert (dataOut === expOut) passCount++;
        else $error("FAIL %s dataOut got %h expected %h", tag, dataOut, expOut);
    endtask

    task automatic drive(input logic rst, input logic [WIDTH-1:0] din, input logic ie,
                         input logic oe);
        @(negedge clock);
        reset              = rst;
        regBus.dataIn      = din;
        regBus.inEnable    = ie;
        regBus.outEnable   = oe;
        if (rst) model = RESET_VALUE;
    endtask

    task automatic edgeCheck(input string tag);
        @(posedge clock);
        if (reset !== 1'b1 && regBus.inEnable === 1'b1) model = regBus.dataIn;
        #1;
        check(tag);
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        model      = RESET_VALUE;
        reset              = 1'b1;
        regBus.dataIn      = '0;
        regBus.inEnable    = 1'b0;
        regBus.outEnable   = 1'b0;
        #2;
        check("reset_initial");

        // Write and drive
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        edgeCheck("write_drive");

        // Asynchronous reset mid-cycle with bus released
        drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model = RESET_VALUE;
        #1;
        check("async_reset");
        reset = 1'b0;

        // Write without drive
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        edgeCheck("preload_ones");
        drive(1'b0, 32'h0000_0000, 1'b1, 1'b0);
        edgeCheck("write_no_drive");

        // Drive only, then drop outEnable without a clock
        drive(1'b0, 32'hA5A5_5A5A, 1'b1, 1'b0);
        edgeCheck("preload_a5");
        drive(1'b0, 32'h1111_2222, 1'b0, 1'b1);
        #1;
        check("drive_only");
        regBus.outEnable = 1'b0;
        #1;
        check("drop_oe");
        edgeCheck("drive_only_hold");

        // Hold
        drive(1'b0, 32'h0000_0000, 1'b1, 1'b0);
        edgeCheck("preload_zero");
        drive(1'b0, 32'h0000_0001, 1'b0, 1'b0);
        edgeCheck("hold");

        // Simultaneous write and drive: old value before edge, new value after
        drive(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        check("no_bypass_before");
        edgeCheck("no_bypass_after");

        // Unknown write enable must not load
        drive(1'b0, 32'hCAFE_F00D, 1'bx, 1'b1);
        edgeCheck("x_enable");

        // Reset priority over a pending write
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        edgeCheck("reset_priority");
        drive(1'b0, 32'h1234_5678, 1'b1, 1'b1);
        edgeCheck("after_reset_release");

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
            #1;
            check("rand_pre");
            edgeCheck("rand_post");
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed %0d total %0d", passCount, totalCount);
        $fatal(1);
    end
endmodule
